// File: rtl/uart_cfg_sequencer_if.sv
// Configuration bus between the sequencer and the uDMA UART cfg port.
// The master issues requests; the slave accepts them and returns read data.
interface uart_cfg_sequencer_if;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic        cfg_ready_i;
  logic [31:0] cfg_data_i;

  modport master (
    output cfg_addr_o,
    output cfg_data_o,
    output cfg_valid_o,
    output cfg_rwn_o,
    input  cfg_ready_i,
    input  cfg_data_i
  );

  modport slave (
    input  cfg_addr_o,
    input  cfg_data_o,
    input  cfg_valid_o,
    input  cfg_rwn_o,
    output cfg_ready_i,
    output cfg_data_i
  );
endinterface

// File: rtl/uart_cfg_sequencer.sv
// Polls the uDMA UART STATUS register until idle, then writes SETUP and the
// enabled RX/TX channel registers over the cfg bus, one request at a time.
module uart_cfg_sequencer #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20,
  parameter int POLL_MAX       = 1024
) (
  input  logic                      sys_clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [15:0]               clkdiv_i,
  input  logic                      parity_en_i,
  input  logic [1:0]                bits_i,
  input  logic                      stop2_i,
  input  logic                      rx_ena_i,
  input  logic                      tx_ena_i,
  input  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] tx_saddr_i,
  input  logic [TRANS_SIZE-1:0]     rx_size_i,
  input  logic [TRANS_SIZE-1:0]     tx_size_i,
  input  logic                      rx_cont_i,
  input  logic                      tx_cont_i,
  uart_cfg_sequencer_if.master      cfg,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  localparam logic [4:0] ADDR_RX_SADDR = 5'd0;
  localparam logic [4:0] ADDR_RX_SIZE  = 5'd1;
  localparam logic [4:0] ADDR_RX_CFG   = 5'd2;
  localparam logic [4:0] ADDR_TX_SADDR = 5'd4;
  localparam logic [4:0] ADDR_TX_SIZE  = 5'd5;
  localparam logic [4:0] ADDR_TX_CFG   = 5'd6;
  localparam logic [4:0] ADDR_STATUS   = 5'd8;
  localparam logic [4:0] ADDR_SETUP    = 5'd9;

  typedef enum logic [3:0] {
    IDLE,
    POLL,
    SETUP,
    RX_SADDR,
    RX_SIZE,
    RX_CFG,
    TX_SADDR,
    TX_SIZE,
    TX_CFG,
    FIN
  } state_e;

  state_e state_q, state_d;
  state_e afterAccept;

  logic [15:0]               clkdiv_q;
  logic                      parityEn_q;
  logic [1:0]                bits_q;
  logic                      stop2_q;
  logic                      rxEna_q;
  logic                      txEna_q;
  logic [L2_AWIDTH_NOAL-1:0] rxSaddr_q;
  logic [L2_AWIDTH_NOAL-1:0] txSaddr_q;
  logic [TRANS_SIZE-1:0]     rxSize_q;
  logic [TRANS_SIZE-1:0]     txSize_q;
  logic                      rxCont_q;
  logic                      txCont_q;

  logic        valid_q, valid_d;
  logic        rwn_q, rwn_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abortPend_q, abortPend_d;
  logic [CNT_W-1:0] pollCnt_q, pollCnt_d;

  logic        startAcc;
  logic        busState;
  logic        accept;
  logic        abortReq;
  logic        statusIdle;
  logic        pollLast;
  logic        timeout;
  logic        issue;
  logic [4:0]  reqAddr;
  logic [31:0] reqData;
  logic [31:0] setupWord;
  logic        unusedStatusBits;

  assign startAcc   = (state_q == IDLE) && start_i;
  assign busState   = (state_q != IDLE) && (state_q != FIN);
  assign accept     = valid_q && cfg.cfg_ready_i;
  assign abortReq   = abort_i || abortPend_q;
  assign statusIdle = (cfg.cfg_data_i[1:0] == 2'b00);
  assign pollLast   = (pollCnt_q == CNT_W'(POLL_MAX - 1));
  assign timeout    = (state_q == POLL) && accept && !statusIdle && pollLast;
  // A new request goes out only from a gap cycle and never once an abort is seen.
  assign issue      = busState && !valid_q && !abortReq;
  assign setupWord  = {clkdiv_q, 6'b0, rxEna_q, txEna_q, 4'b0, stop2_q, bits_q, parityEn_q};
  assign unusedStatusBits = ^cfg.cfg_data_i[31:2];

  // Snapshot of the requested configuration, taken only when a start is accepted.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clkdiv_q   <= '0;
      parityEn_q <= 1'b0;
      bits_q     <= '0;
      stop2_q    <= 1'b0;
      rxEna_q    <= 1'b0;
      txEna_q    <= 1'b0;
      rxSaddr_q  <= '0;
      txSaddr_q  <= '0;
      rxSize_q   <= '0;
      txSize_q   <= '0;
      rxCont_q   <= 1'b0;
      txCont_q   <= 1'b0;
    end else if (startAcc) begin
      clkdiv_q   <= clkdiv_i;
      parityEn_q <= parity_en_i;
      bits_q     <= bits_i;
      stop2_q    <= stop2_i;
      rxEna_q    <= rx_ena_i;
      txEna_q    <= tx_ena_i;
      rxSaddr_q  <= rx_saddr_i;
      txSaddr_q  <= tx_saddr_i;
      rxSize_q   <= rx_size_i;
      txSize_q   <= tx_size_i;
      rxCont_q   <= rx_cont_i;
      txCont_q   <= tx_cont_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Successor of each bus state once its transaction has been accepted.
  always_comb begin
    afterAccept = FIN;
    case (state_q)
      POLL: begin
        if (statusIdle) begin
          afterAccept = SETUP;
        end else if (pollLast) begin
          afterAccept = FIN;
        end else begin
          afterAccept = POLL;
        end
      end
      SETUP:    afterAccept = rxEna_q ? RX_SADDR : (txEna_q ? TX_SADDR : FIN);
      RX_SADDR: afterAccept = RX_SIZE;
      RX_SIZE:  afterAccept = RX_CFG;
      RX_CFG:   afterAccept = txEna_q ? TX_SADDR : FIN;
      TX_SADDR: afterAccept = TX_SIZE;
      TX_SIZE:  afterAccept = TX_CFG;
      default:  afterAccept = FIN;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = POLL;
        end
      end
      FIN: state_d = IDLE;
      default: begin
        if (accept) begin
          state_d = abortReq ? FIN : afterAccept;
        end else if (!valid_q && abortReq) begin
          state_d = FIN;
        end
      end
    endcase
  end

  always_comb begin
    reqAddr = 5'd0;
    reqData = 32'd0;
    case (state_q)
      POLL:     reqAddr = ADDR_STATUS;
      SETUP: begin
        reqAddr = ADDR_SETUP;
        reqData = setupWord;
      end
      RX_SADDR: begin
        reqAddr = ADDR_RX_SADDR;
        reqData = 32'(rxSaddr_q);
      end
      RX_SIZE: begin
        reqAddr = ADDR_RX_SIZE;
        reqData = 32'(rxSize_q);
      end
      RX_CFG: begin
        reqAddr = ADDR_RX_CFG;
        reqData = {27'd0, 1'b1, 3'd0, rxCont_q};
      end
      TX_SADDR: begin
        reqAddr = ADDR_TX_SADDR;
        reqData = 32'(txSaddr_q);
      end
      TX_SIZE: begin
        reqAddr = ADDR_TX_SIZE;
        reqData = 32'(txSize_q);
      end
      TX_CFG: begin
        reqAddr = ADDR_TX_CFG;
        reqData = {27'd0, 1'b1, 3'd0, txCont_q};
      end
      default: begin
        reqAddr = 5'd0;
        reqData = 32'd0;
      end
    endcase
  end

  // Bus fields only change when a request is launched, so they hold through stalls.
  always_comb begin
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rwn_d       = rwn_q;
    err_d       = err_q;
    pollCnt_d   = pollCnt_q;
    abortPend_d = busState ? (abortPend_q || abort_i) : 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);

    if (issue) begin
      valid_d = 1'b1;
      addr_d  = reqAddr;
      data_d  = reqData;
      rwn_d   = (state_q == POLL);
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (startAcc) begin
      err_d     = 1'b0;
      pollCnt_d = '0;
    end else begin
      if (timeout && !abortReq) begin
        err_d = 1'b1;
      end
      if ((state_q == POLL) && accept && (pollCnt_q != CNT_W'(POLL_MAX))) begin
        pollCnt_d = pollCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q     <= 1'b0;
      rwn_q       <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abortPend_q <= 1'b0;
      pollCnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      rwn_q       <= rwn_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      abortPend_q <= abortPend_d;
      pollCnt_q   <= pollCnt_d;
    end
  end

  assign cfg.cfg_valid_o = valid_q;
  assign cfg.cfg_rwn_o   = rwn_q;
  assign cfg.cfg_addr_o  = addr_q;
  assign cfg.cfg_data_o  = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
